// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle sequencer and the CPU datapath/memory port.
// master = sequencer side, slave = datapath/memory side.
interface multicycle_ctrl_if;
  logic [4:0] ir_op;
  logic       mem_ack;
  logic       cond_true;
  logic       mem_req;
  logic       mem_we;
  logic       addr_pc;
  logic       ir_en;
  logic [1:0] ext_sel;
  logic       alu_src_imm;
  logic       pc_en;
  logic       pc_src;
  logic       reg_we;
  logic       mem_to_reg;
  logic       halted;
  logic       illegal_op;
  logic       bus_err;

  modport master (
    input  ir_op, mem_ack, cond_true,
    output mem_req, mem_we, addr_pc, ir_en, ext_sel, alu_src_imm,
           pc_en, pc_src, reg_we, mem_to_reg, halted, illegal_op, bus_err
  );

  modport slave (
    output ir_op, mem_ack, cond_true,
    input  mem_req, mem_we, addr_pc, ir_en, ext_sel, alu_src_imm,
           pc_en, pc_src, reg_we, mem_to_reg, halted, illegal_op, bus_err
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU sequencer: FETCH/DECODE/EXEC/MEM/WB with a per-request memory timeout.
// Memory requests hold until mem_ack; a request unanswered for MAX_WAIT cycles latches bus_err and halts.
module multicycle_ctrl #(
  parameter int TO_W     = 8,
  parameter int MAX_WAIT = 200
) (
  input logic               clk,
  input logic               rst,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      op_q, op_d;
  logic [1:0]      ext_q, ext_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            ill_q, ill_d;
  logic            berr_q, berr_d;

  logic mem_req, mem_we, addr_pc, ir_en, alu_src_imm;
  logic pc_en, pc_src, reg_we, mem_to_reg, halted;
  logic [1:0] ext_sel;

  logic is_alu_reg, is_mem, is_alu_imm, is_br, is_jmp, is_halt, is_ill;
  logic to_limit, in_instr;

  assign is_alu_reg = (op_q[4:3] == 2'b00);
  assign is_mem     = (op_q[4:3] == 2'b01);
  assign is_alu_imm = (op_q[4:3] == 2'b10);
  assign is_br      = (op_q == 5'b11000);
  assign is_jmp     = (op_q == 5'b11001);
  assign is_halt    = (op_q == 5'b11111);
  assign is_ill     = (op_q[4:3] == 2'b11) && !is_br && !is_jmp && !is_halt;

  // Limit is checked against the count before this cycle's increment, so the
  // request lives exactly MAX_WAIT cycles and an ack in the last one still wins.
  assign to_limit = (to_q == TO_W'(MAX_WAIT - 1));

  assign in_instr = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                    (state_q == S_MEM)    || (state_q == S_WB);

  function automatic logic [1:0] ext_decode(input logic [4:0] op);
    logic [1:0] sel;
    sel = 2'b00;
    case (op[4:3])
      2'b00:   sel = 2'b00;
      2'b01:   sel = 2'b00;
      2'b10:   sel = 2'b01;
      default: begin
        if (op == 5'b11000)      sel = 2'b10;
        else if (op == 5'b11001) sel = 2'b11;
        else                     sel = 2'b00;
      end
    endcase
    return sel;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 5'b0;
      ext_q   <= 2'b00;
      to_q    <= '0;
      ill_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ext_q   <= ext_d;
      to_q    <= to_d;
      ill_q   <= ill_d;
      berr_q  <= berr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    ext_d       = ext_q;
    to_d        = to_q;
    ill_d       = ill_q;
    berr_d      = berr_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_pc     = 1'b0;
    ir_en       = 1'b0;
    pc_en       = 1'b0;
    pc_src      = 1'b0;
    reg_we      = 1'b0;
    mem_to_reg  = 1'b0;
    halted      = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        to_d    = '0;
      end

      S_FETCH: begin
        mem_req = 1'b1;
        addr_pc = 1'b1;
        if (bus.mem_ack) begin
          ir_en   = 1'b1;
          op_d    = bus.ir_op;
          ext_d   = ext_decode(bus.ir_op);
          state_d = S_DECODE;
        end else if (to_limit) begin
          berr_d  = 1'b1;
          state_d = S_HALT;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end

      S_DECODE: begin
        state_d = S_EXEC;
      end

      S_EXEC: begin
        if (is_alu_reg || is_alu_imm) begin
          state_d = S_WB;
        end else if (is_mem) begin
          state_d = S_MEM;
          to_d    = '0;
        end else if (is_br) begin
          pc_en   = 1'b1;
          pc_src  = bus.cond_true;
          state_d = S_FETCH;
          to_d    = '0;
        end else if (is_jmp) begin
          pc_en   = 1'b1;
          pc_src  = 1'b1;
          state_d = S_FETCH;
          to_d    = '0;
        end else if (is_halt) begin
          state_d = S_HALT;
        end else if (is_ill) begin
          // Unknown 11xxx opcode retires as a NOP but is remembered.
          ill_d   = 1'b1;
          pc_en   = 1'b1;
          pc_src  = 1'b0;
          state_d = S_FETCH;
          to_d    = '0;
        end
      end

      S_MEM: begin
        mem_req = 1'b1;
        addr_pc = 1'b0;
        mem_we  = op_q[2];
        if (bus.mem_ack) begin
          if (op_q[2]) begin
            pc_en   = 1'b1;
            pc_src  = 1'b0;
            state_d = S_FETCH;
            to_d    = '0;
          end else begin
            state_d = S_WB;
          end
        end else if (to_limit) begin
          berr_d  = 1'b1;
          state_d = S_HALT;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end

      S_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = is_mem;
        pc_en      = 1'b1;
        pc_src     = 1'b0;
        state_d    = S_FETCH;
        to_d       = '0;
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Immediate select and ALU-B mux only mean something while an instruction is in flight.
  assign ext_sel     = in_instr ? ext_q : 2'b00;
  assign alu_src_imm = in_instr && (is_mem || is_alu_imm);

  assign bus.mem_req     = mem_req;
  assign bus.mem_we      = mem_we;
  assign bus.addr_pc     = addr_pc;
  assign bus.ir_en       = ir_en;
  assign bus.ext_sel     = ext_sel;
  assign bus.alu_src_imm = alu_src_imm;
  assign bus.pc_en       = pc_en;
  assign bus.pc_src      = pc_src;
  assign bus.reg_we      = reg_we;
  assign bus.mem_to_reg  = mem_to_reg;
  assign bus.halted      = halted;
  assign bus.illegal_op  = ill_q;
  assign bus.bus_err     = berr_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: table of instructions plus hand-written timeout/halt/reset sequences.
module tb_multicycle_ctrl;

  logic clk;
  logic rst;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.TO_W(8), .MAX_WAIT(200)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0] op;
    logic       cond;
    logic       stray;
    int w1, w2;
    int cyc, ext, imm, pc_en, pc_src, reg_we, m2r, mem_cyc, mem_we, ill, halt;
  } vec_t;

  typedef struct {
    int cyc, fetch_cyc, ir_en, pc_en, pc_src, reg_we, m2r, mem_cyc, mem_we, fetch_we, ext, imm, halt;
  } obs_t;

  vec_t vec[11];
  obs_t o;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int all_outs();
    return int'({bus.mem_req, bus.mem_we, bus.addr_pc, bus.ir_en, bus.ext_sel,
                 bus.alu_src_imm, bus.pc_en, bus.pc_src, bus.reg_we, bus.mem_to_reg,
                 bus.halted, bus.illegal_op, bus.bus_err});
  endfunction

  // Leaves the caller at a falling edge in the first FETCH cycle.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.mem_ack = 1'b0;
    #1;
    chk("reset_outs_zero", all_outs(), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_after_release", all_outs(), 0);
    @(negedge clk);
    chk("fetch_after_idle", int'(bus.mem_req && bus.addr_pc), 1);
  endtask

  // Entered at a falling edge in the instruction's first FETCH cycle; returns at the
  // falling edge of the next FETCH (or on HALT). w=0 means never acknowledge.
  task automatic run_instr(input logic [4:0] op, input logic cond, input logic stray,
                           input int w1, input int w2, output obs_t r);
    int fcnt, mcnt;
    logic left_fetch, ack;
    r = '{default: 0};
    r.cyc = -1;
    fcnt = 0; mcnt = 0; left_fetch = 1'b0;
    bus.ir_op = op;
    bus.cond_true = cond;
    for (int cyc = 0; cyc < 450; cyc++) begin
      if (bus.halted) begin
        r.halt = 1; r.cyc = cyc; break;
      end
      if (bus.mem_req && bus.addr_pc && left_fetch) begin
        r.cyc = cyc; break;
      end
      if (bus.mem_req && bus.addr_pc) begin
        ack = (w1 != 0) && (fcnt == w1 - 1);
        fcnt++;
      end else if (bus.mem_req) begin
        ack = (w2 != 0) && (mcnt == w2 - 1);
        mcnt++;
      end else begin
        ack = stray;
      end
      bus.mem_ack = ack;
      #1;
      if (!(bus.mem_req && bus.addr_pc) && !left_fetch) begin
        left_fetch = 1'b1;
        r.ext = int'(bus.ext_sel);
        r.imm = int'(bus.alu_src_imm);
      end
      if (bus.mem_req && bus.addr_pc) r.fetch_we += int'(bus.mem_we);
      if (bus.mem_req && !bus.addr_pc) begin
        r.mem_cyc++;
        r.mem_we = int'(bus.mem_we);
      end
      r.ir_en  += int'(bus.ir_en);
      r.pc_en  += int'(bus.pc_en);
      r.reg_we += int'(bus.reg_we);
      if (bus.pc_en)  r.pc_src = int'(bus.pc_src);
      if (bus.reg_we) r.m2r    = int'(bus.mem_to_reg);
      @(negedge clk);
    end
    bus.mem_ack = 1'b0;
    r.fetch_cyc = fcnt;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, got running, expected finished");
    $fatal(1);
  end

  initial begin
    logic got_mem;
    rst = 1'b0;
    bus.ir_op = 5'b0;
    bus.mem_ack = 1'b0;
    bus.cond_true = 1'b0;

    //          op        cond  stry w1   w2  cyc ext imm pce src we m2r mc mw ill halt
    vec[0]  = '{5'b00010, 1'b0, 1'b0, 1, 0,   4, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0};
    vec[1]  = '{5'b01000, 1'b0, 1'b0, 1, 3,   7, 0, 1, 1, 0, 1, 1, 3, 0, 0, 0};
    vec[2]  = '{5'b01100, 1'b0, 1'b0, 2, 3,   7, 0, 1, 1, 0, 0, 0, 3, 1, 0, 0};
    vec[3]  = '{5'b11000, 1'b1, 1'b0, 1, 0,   3, 2, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    vec[4]  = '{5'b11000, 1'b0, 1'b0, 1, 0,   3, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    vec[5]  = '{5'b11001, 1'b0, 1'b0, 1, 0,   3, 3, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    vec[6]  = '{5'b10101, 1'b0, 1'b0, 1, 0,   4, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0};
    vec[7]  = '{5'b00111, 1'b0, 1'b1, 3, 0,   6, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0};
    vec[8]  = '{5'b11010, 1'b0, 1'b0, 1, 0,   3, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
    vec[9]  = '{5'b01000, 1'b0, 1'b1, 2, 1,   6, 0, 1, 1, 0, 1, 1, 1, 0, 1, 0};
    vec[10] = '{5'b11111, 1'b0, 1'b0, 1, 0,   3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};

    do_reset();

    for (int i = 0; i < 11; i++) begin
      run_instr(vec[i].op, vec[i].cond, vec[i].stray, vec[i].w1, vec[i].w2, o);
      chk($sformatf("v%0d_cycles", i), o.cyc, vec[i].cyc);
      chk($sformatf("v%0d_ir_en", i), o.ir_en, 1);
      chk($sformatf("v%0d_ext_sel", i), o.ext, vec[i].ext);
      chk($sformatf("v%0d_alu_src_imm", i), o.imm, vec[i].imm);
      chk($sformatf("v%0d_pc_en", i), o.pc_en, vec[i].pc_en);
      if (vec[i].pc_en != 0) chk($sformatf("v%0d_pc_src", i), o.pc_src, vec[i].pc_src);
      chk($sformatf("v%0d_reg_we", i), o.reg_we, vec[i].reg_we);
      if (vec[i].reg_we != 0) chk($sformatf("v%0d_mem_to_reg", i), o.m2r, vec[i].m2r);
      chk($sformatf("v%0d_mem_cycles", i), o.mem_cyc, vec[i].mem_cyc);
      if (vec[i].mem_cyc != 0) chk($sformatf("v%0d_mem_we", i), o.mem_we, vec[i].mem_we);
      chk($sformatf("v%0d_fetch_we", i), o.fetch_we, 0);
      chk($sformatf("v%0d_illegal_op", i), int'(bus.illegal_op), vec[i].ill);
      chk($sformatf("v%0d_halted", i), o.halt, vec[i].halt);
    end

    // Parked in HALT: stray acks must not restart anything.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.mem_ack = (i % 2 == 0);
      #1;
      chk($sformatf("halt_quiet_%0d", i),
          int'({bus.halted, bus.mem_req, bus.pc_en, bus.ir_en, bus.reg_we}), 5'b10000);
    end
    bus.mem_ack = 1'b0;

    // FETCH never acknowledged: bus error after exactly 200 request cycles.
    do_reset();
    run_instr(5'b00010, 1'b0, 1'b0, 0, 0, o);
    chk("fetch_to_cycles", o.cyc, 200);
    chk("fetch_to_req_cycles", o.fetch_cyc, 200);
    chk("fetch_to_halted", o.halt, 1);
    chk("fetch_to_bus_err", int'(bus.bus_err), 1);
    chk("fetch_to_ir_en", o.ir_en, 0);

    // Ack on the 200th cycle wins over the timeout.
    do_reset();
    run_instr(5'b00010, 1'b0, 1'b0, 200, 0, o);
    chk("fetch_ack200_cycles", o.cyc, 203);
    chk("fetch_ack200_halted", o.halt, 0);
    chk("fetch_ack200_bus_err", int'(bus.bus_err), 0);
    chk("fetch_ack200_reg_we", o.reg_we, 1);

    // Load whose data phase is never acknowledged.
    run_instr(5'b01000, 1'b0, 1'b0, 1, 0, o);
    chk("mem_to_cycles", o.cyc, 203);
    chk("mem_to_mem_cycles", o.mem_cyc, 200);
    chk("mem_to_bus_err", int'(bus.bus_err), 1);
    chk("mem_to_reg_we", o.reg_we, 0);
    chk("mem_to_pc_en", o.pc_en, 0);

    // Reset in the middle of a MEM request after the illegal flag was set.
    do_reset();
    run_instr(5'b11010, 1'b0, 1'b0, 1, 0, o);
    chk("pre_rst_illegal", int'(bus.illegal_op), 1);
    bus.ir_op = 5'b01000;
    got_mem = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      bus.mem_ack = bus.mem_req && bus.addr_pc;
      #1;
      if (bus.mem_req && !bus.addr_pc) begin
        got_mem = 1'b1;
        break;
      end
    end
    chk("reached_mem", int'(got_mem), 1);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    chk("mem_req_held", int'(bus.mem_req), 1);
    rst = 1'b1;
    #1;
    chk("rst_mem_req_drop", int'(bus.mem_req), 0);
    chk("rst_clears_sticky", int'({bus.illegal_op, bus.bus_err}), 0);
    chk("rst_no_strobes", int'({bus.pc_en, bus.reg_we, bus.ir_en}), 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rst_hold_quiet_%0d", i), all_outs(), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_release_idle", int'(bus.mem_req), 0);
    @(negedge clk);
    #1;
    chk("rst_release_fetch", int'(bus.mem_req && bus.addr_pc), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
